// File: rtl/myy_booth_datapath_if.sv
// Bus between the Booth multiplier control unit (master) and its
// operational block (slave).
//   a, b : signed operands, driven by the master
//   y    : control word y[10:1], driven by the master
//   x    : logic conditions back to the master {RR sign, RB[-1], RB[0]}
//   p    : 2N-bit product {RR[N-1:0], RB}
interface myy_booth_datapath_if #(
    parameter int N = 4
);
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [10:1]    y;
    logic [2:0]     x;
    logic [2*N-1:0] p;

    modport master (
        output a,
        output b,
        output y,
        input  x,
        input  p
    );

    modport slave (
        input  a,
        input  b,
        input  y,
        output x,
        output p
    );
endinterface

// File: rtl/myy_booth_datapath.sv
// Operational block of a signed radix-2 Booth multiplier.
// Registers: RA (multiplicand), RB + RB[-1] (multiplier / low product),
// RR (N+1-bit accumulator / high product, wide enough that RR +/- RA
// never overflows for any operands).
// Ports:
//   clk  - rising-edge clock
//   set  - asynchronous active-high reset, clears every register
//   bus  - slave side of myy_booth_datapath_if (a, b, y in; x, p out)
module myy_booth_datapath #(
    parameter int N = 4
) (
    input logic                  clk,
    input logic                  set,
    myy_booth_datapath_if.slave  bus
);

    logic [N-1:0] ra_q, ra_d;
    logic [N-1:0] rb_q, rb_d;
    logic         rbm1_q, rbm1_d;
    logic [N:0]   rr_q, rr_d;

    logic [N:0]   ra_x;
    logic [N:0]   op;
    logic         cin;
    logic [N:0]   sum;

    // y10 is reserved and deliberately ignored.
    logic unused_y10;
    assign unused_y10 = bus.y[10];

    // Adder: RR + OP + cin; subtraction is RR + ~RAx + 1. Carry-out dropped.
    always_comb begin
        ra_x = {ra_q[N-1], ra_q};
        op   = '0;
        if (bus.y[6]) begin
            if (bus.y[5]) begin
                op = ~ra_x;
            end else if (bus.y[4]) begin
                op = ra_x;
            end
        end
        cin = bus.y[6] & bus.y[5];
        sum = rr_q + op + {{N{1'b0}}, cin};
    end

    always_comb begin
        ra_d   = ra_q;
        rb_d   = rb_q;
        rbm1_d = rbm1_q;
        rr_d   = rr_q;

        if (bus.y[1]) begin
            ra_d = bus.a;
        end

        if (bus.y[3]) begin
            if (bus.y[2]) begin
                rb_d   = bus.b;
                rbm1_d = 1'b0;
            end else begin
                // RR[0] enters from the left using the pre-edge RR, so a
                // simultaneous RR shift moves {RR, RB, RB[-1]} as one unit.
                rb_d   = {rr_q[0], rb_q[N-1:1]};
                rbm1_d = rb_q[0];
            end
        end

        if (bus.y[7]) begin
            if (bus.y[8]) begin
                rr_d = '0;
            end else if (bus.y[9]) begin
                rr_d = sum;
            end else begin
                rr_d = {rr_q[N], rr_q[N:1]};
            end
        end
    end

    always_ff @(posedge clk or posedge set) begin
        if (set) begin
            ra_q   <= '0;
            rb_q   <= '0;
            rbm1_q <= 1'b0;
            rr_q   <= '0;
        end else begin
            ra_q   <= ra_d;
            rb_q   <= rb_d;
            rbm1_q <= rbm1_d;
            rr_q   <= rr_d;
        end
    end

    assign bus.x = {rr_q[N], rbm1_q, rb_q[0]};
    assign bus.p = {rr_q[N-1:0], rb_q};

endmodule

// File: tb/tb_myy_booth_datapath.sv
module tb_myy_booth_datapath;

    localparam logic [10:1] W_LOAD  = 10'b0111000111;
    localparam logic [10:1] W_ADD   = 10'b0101101000;
    localparam logic [10:1] W_SUB   = 10'b0101110000;
    localparam logic [10:1] W_NOP   = 10'b0101100000;
    localparam logic [10:1] W_SHIFT = 10'b0001000100;
    localparam logic [10:1] W_HOLD  = 10'b0000000000;

    logic clk = 1'b0;
    logic set = 1'b1;
    int   total = 0;
    int   bad   = 0;

    myy_booth_datapath_if #(.N(4)) bus ();

    myy_booth_datapath #(.N(4)) dut (
        .clk (clk),
        .set (set),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Apply one control word on the falling edge; return 1 time unit after
    // the following rising edge, where outputs are sampled.
    task automatic step(input logic [10:1] w);
        @(negedge clk);
        bus.y = w;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        total++;
        if (bus.p !== 8'h00 || bus.x !== 3'b000) begin
            bad++;
            $display("FAIL reset_state p=%h x=%b required p=00 x=000", bus.p, bus.x);
        end
        @(negedge clk);
        set = 1'b0;
        $display("reset released");
    endtask

    task automatic test_load_and_step();
        bus.a = 4'd3;
        bus.b = 4'd5;
        step(W_LOAD);
        total++;
        if (bus.p !== 8'h05 || bus.x !== 3'b001) begin
            bad++;
            $display("FAIL load p=%h x=%b required p=05 x=001", bus.p, bus.x);
        end
        step(W_SUB);
        total++;
        if (bus.p !== 8'hD5 || bus.x !== 3'b101) begin
            bad++;
            $display("FAIL first_sub p=%h x=%b required p=d5 x=101", bus.p, bus.x);
        end
        step(W_SHIFT);
        total++;
        if (bus.p !== 8'hEA || bus.x !== 3'b110) begin
            bad++;
            $display("FAIL first_shift p=%h x=%b required p=ea x=110", bus.p, bus.x);
        end
        $display("load/step p=%h x=%b", bus.p, bus.x);
    endtask

    // Bench plays the control unit: op chosen from x, then a shift, N times.
    task automatic mult(input logic [3:0] a_v, input logic [3:0] b_v,
                        input logic [7:0] exp_p, input string nm);
        bus.a = a_v;
        bus.b = b_v;
        step(W_LOAD);
        for (int i = 0; i < 4; i++) begin
            case (bus.x[1:0])
                2'b10:   step(W_ADD);
                2'b01:   step(W_SUB);
                default: step(W_NOP);
            endcase
            step(W_SHIFT);
        end
        total++;
        if (bus.p !== exp_p) begin
            bad++;
            $display("FAIL %s p=%h required %h", nm, bus.p, exp_p);
        end else begin
            $display("mult %s p=%h", nm, bus.p);
        end
    endtask

    task automatic test_multiply();
        mult(4'd3,  4'd5,  8'h0F, "3x5");
        mult(4'hD,  4'd5,  8'hF1, "-3x5");
        mult(4'h8,  4'h8,  8'h40, "-8x-8");
        mult(4'd7,  4'h8,  8'hC8, "7x-8");
        total++;
        if (bus.x !== 3'b110) begin
            bad++;
            $display("FAIL x_after_7x-8 x=%b required 110", bus.x);
        end
    endtask

    task automatic test_priority_hold();
        bus.a = 4'd1;
        bus.b = 4'b0110;
        step(W_LOAD);
        step(W_ADD);
        total++;
        if (bus.p !== 8'h16) begin
            bad++;
            $display("FAIL add_one p=%h required 16", bus.p);
        end
        step(10'b0111000000);
        total++;
        if (bus.p !== 8'h06) begin
            bad++;
            $display("FAIL clear_priority p=%h required 06", bus.p);
        end
        step(W_ADD);
        step(10'b0100101000);
        total++;
        if (bus.p !== 8'h16) begin
            bad++;
            $display("FAIL rr_hold_y7_off p=%h required 16", bus.p);
        end
        bus.b = 4'd9;
        step(10'b0000000010);
        total++;
        if (bus.p !== 8'h16 || bus.x !== 3'b000) begin
            bad++;
            $display("FAIL y2_alone p=%h x=%b required p=16 x=000", bus.p, bus.x);
        end
        step(10'b1000000000);
        total++;
        if (bus.p !== 8'h16 || bus.x !== 3'b000) begin
            bad++;
            $display("FAIL y10_alone p=%h x=%b required p=16 x=000", bus.p, bus.x);
        end
        $display("priority/hold p=%h", bus.p);
    endtask

    task automatic test_async_reset();
        bus.a = 4'd3;
        bus.b = 4'd5;
        step(W_LOAD);
        #2;
        set = 1'b1;
        #1;
        total++;
        if (bus.p !== 8'h00 || bus.x !== 3'b000) begin
            bad++;
            $display("FAIL async_reset p=%h x=%b required p=00 x=000", bus.p, bus.x);
        end
        for (int i = 0; i < 2; i++) begin
            step(W_LOAD);
            total++;
            if (bus.p !== 8'h00 || bus.x !== 3'b000) begin
                bad++;
                $display("FAIL reset_held p=%h x=%b required p=00 x=000", bus.p, bus.x);
            end
        end
        @(negedge clk);
        set = 1'b0;
        step(W_LOAD);
        total++;
        if (bus.p !== 8'h05 || bus.x !== 3'b001) begin
            bad++;
            $display("FAIL load_after_reset p=%h x=%b required p=05 x=001", bus.p, bus.x);
        end
        $display("async reset done p=%h", bus.p);
    endtask

    task automatic test_hold_stable();
        mult(4'd7, 4'h8, 8'hC8, "7x-8_again");
        for (int i = 0; i < 10; i++) begin
            if (i == 5) begin
                bus.a = 4'd2;
                bus.b = 4'd1;
            end
            step(W_HOLD);
            total++;
            if (bus.p !== 8'hC8 || bus.x !== 3'b110) begin
                bad++;
                $display("FAIL hold_cycle%0d p=%h x=%b required p=c8 x=110", i, bus.p, bus.x);
            end
        end
        $display("hold stable p=%h x=%b", bus.p, bus.x);
    endtask

    initial begin
        bus.a = '0;
        bus.b = '0;
        bus.y = W_HOLD;
        test_reset();
        test_load_and_step();
        test_multiply();
        test_priority_hold();
        test_async_reset();
        test_hold_stable();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
